nonarch_reg_bank: RTL and testbench

- Parametrised successor to the single 32-bit nonarchitectural latch (A/B/ALUOut/MDR style) of the multicycle CPU datapath.
- Holds NCH independent WIDTH-bit datapath registers, each with its own load enable and valid flag.
- Adds a one-deep snapshot/restore shadow copy and a flush, used for exception rollback and abort of multicycle instructions.
- Sits between the register file/ALU/memory outputs and the next-state datapath muxes.

---
 rtl/nonarch_reg_bank.sv | 66 ++++++
 tb/tb_nonarch_reg_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonarch_reg_bank.sv
// Multi-channel nonarchitectural datapath register bank.
// One-deep snapshot/restore shadow copy and a flush for rollback.
module nonarch_reg_bank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_we,
  input  logic [NCH*WIDTH-1:0] i_x,
  input  logic                 i_snap,
  input  logic                 i_restore,
  input  logic                 i_flush,
  output logic [NCH*WIDTH-1:0] o_y,
  output logic [NCH-1:0]       o_valid,
  output logic                 o_snap_valid
);

  logic [NCH*WIDTH-1:0] data_q;
  logic [NCH-1:0]       valid_q;
  logic [NCH*WIDTH-1:0] shd_data_q;
  logic [NCH-1:0]       shd_valid_q;
  logic                 snap_valid_q;
  logic                 do_restore;

  assign do_restore = i_restore & snap_valid_q;

  // Live channels: restore beats flush beats per-channel writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= {NCH{RST_VAL}};
      valid_q <= '0;
    end else if (do_restore) begin
      data_q  <= shd_data_q;
      valid_q <= shd_valid_q;
    end else if (i_flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (i_we[k]) begin
          data_q[k*WIDTH +: WIDTH] <= i_x[k*WIDTH +: WIDTH];
          valid_q[k]               <= 1'b1;
        end
      end
    end
  end

  // Shadow copy captures pre-edge live state; snap+restore swaps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shd_data_q   <= {NCH{RST_VAL}};
      shd_valid_q  <= '0;
      snap_valid_q <= 1'b0;
    end else if (i_snap) begin
      shd_data_q   <= data_q;
      shd_valid_q  <= valid_q;
      snap_valid_q <= 1'b1;
    end
  end

  assign o_y          = data_q;
  assign o_valid      = valid_q;
  assign o_snap_valid = snap_valid_q;

endmodule

// File: tb/tb_nonarch_reg_bank.sv
// Bench for nonarch_reg_bank: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_nonarch_reg_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   we = '0;
  logic [127:0] x = '0;
  logic         snap = 1'b0;
  logic         restore = 1'b0;
  logic         flush = 1'b0;
  logic [127:0] y;
  logic [3:0]   valid;
  logic         snap_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] md [4];
  logic [31:0] sd [4];
  logic [3:0]  mv;
  logic [3:0]  svd;
  logic        msv;

  nonarch_reg_bank #(
    .WIDTH(32),
    .NCH(4),
    .RST_VAL(32'h0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_we(we),
    .i_x(x),
    .i_snap(snap),
    .i_restore(restore),
    .i_flush(flush),
    .o_y(y),
    .o_valid(valid),
    .o_snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  task automatic cycle(
    input logic r,
    input logic [3:0] w,
    input logic [127:0] d,
    input logic s,
    input logic re,
    input logic f
  );
    logic [31:0] od [4];
    logic [3:0]  ov;
    bit          er;
    rst = r; we = w; x = d;
    snap = s; restore = re; flush = f;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        md[k] = 32'h0;
        sd[k] = 32'h0;
      end
      mv = '0; svd = '0; msv = 1'b0;
    end else begin
      er = re && msv;
      od = sd;
      ov = svd;
      if (s) begin
        sd = md; svd = mv; msv = 1'b1;
      end
      if (er) begin
        md = od; mv = ov;
      end else if (f) begin
        mv = '0;
      end else begin
        for (int k = 0; k < 4; k++)
          if (w[k]) begin
            md[k] = d[k*32 +: 32];
            mv[k] = 1'b1;
          end
      end
    end
    @(posedge clk);
    #1;
    rst = 0; we = '0; snap = 0;
    restore = 0; flush = 0;
  endtask

  task automatic test_reset();
    cycle(1, 4'b0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'b0, '0, 0, 0, 0);
      checks++;
      if (y !== 128'h0 || valid !== 4'b0 || snap_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle%0d y=%h v=%b sv=%b want 0/0000/0",
                 i, y, valid, snap_valid);
      end
    end
  endtask

  task automatic test_write();
    logic [127:0] exp;
    exp = {32'h0, 32'h33333333, 32'h0, 32'h11111111};
    cycle(0, 4'b0101, exp, 0, 0, 0);
    checks++;
    if (y !== exp || valid !== 4'b0101) begin
      errors++;
      $display("FAIL write y=%h v=%b want %h 0101", y, valid, exp);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 4'b0, {4{32'hFFFFFFFF}}, 0, 0, 0);
      checks++;
      if (y !== exp || valid !== 4'b0101) begin
        errors++;
        $display("FAIL hold%0d y=%h v=%b want %h 0101",
                 i, y, valid, exp);
      end
    end
  endtask

  task automatic test_snap_write();
    cycle(1, 4'b0, '0, 0, 0, 0);
    cycle(0, 4'b0001, {96'h0, 32'hAAAA0000}, 0, 0, 0);
    cycle(0, 4'b0001, {96'h0, 32'hBBBB0000}, 1, 0, 0);
    checks++;
    if (y[31:0] !== 32'hBBBB0000 || snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL snap_write ch0=%h sv=%b want BBBB0000 1",
               y[31:0], snap_valid);
    end
    cycle(0, 4'b0, '0, 0, 1, 0);
    checks++;
    if (y[31:0] !== 32'hAAAA0000 || valid !== 4'b0001) begin
      errors++;
      $display("FAIL snap_restore ch0=%h v=%b want AAAA0000 0001",
               y[31:0], valid);
    end
  endtask

  task automatic test_flush_write();
    logic [127:0] d0;
    d0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    cycle(1, 4'b0, '0, 0, 0, 0);
    cycle(0, 4'b1111, d0, 0, 0, 0);
    checks++;
    if (valid !== 4'b1111) begin
      errors++;
      $display("FAIL fill v=%b want 1111", valid);
    end
    cycle(0, 4'b1111, {4{32'h5A5A5A5A}}, 0, 0, 1);
    checks++;
    if (valid !== 4'b0000 || y !== d0) begin
      errors++;
      $display("FAIL flush y=%h v=%b want %h 0000", y, valid, d0);
    end
    cycle(0, 4'b1000, {32'hDEADBEEF, 96'h0}, 0, 0, 0);
    checks++;
    if (valid !== 4'b1000 || y[127:96] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_flush ch3=%h v=%b want DEADBEEF 1000",
               y[127:96], valid);
    end
  endtask

  task automatic test_dropped_restore();
    cycle(1, 4'b0, '0, 0, 0, 0);
    cycle(0, 4'b0010, {64'h0, 32'h12345678, 32'h0}, 0, 1, 0);
    checks++;
    if (y[63:32] !== 32'h12345678 || valid !== 4'b0010 ||
        snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_restore ch1=%h v=%b sv=%b want 12345678 0010 0",
               y[63:32], valid, snap_valid);
    end
  endtask

  task automatic test_swap_reset();
    cycle(1, 4'b0, '0, 0, 0, 0);
    cycle(0, 4'b0001, {96'h0, 32'h1}, 0, 0, 0);
    cycle(0, 4'b0, '0, 1, 0, 0);
    cycle(0, 4'b0001, {96'h0, 32'h2}, 0, 0, 0);
    cycle(0, 4'b0, '0, 1, 1, 0);
    checks++;
    if (y[31:0] !== 32'h1 || snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL swap ch0=%h sv=%b want 1 1", y[31:0], snap_valid);
    end
    cycle(0, 4'b0, '0, 0, 1, 0);
    checks++;
    if (y[31:0] !== 32'h2) begin
      errors++;
      $display("FAIL swap_restore ch0=%h want 2", y[31:0]);
    end
    cycle(1, 4'b0, '0, 1, 0, 0);
    checks++;
    if (y !== 128'h0 || valid !== 4'b0 || snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_snap y=%h v=%b sv=%b want 0", y, valid, snap_valid);
    end
    cycle(0, 4'b0, '0, 0, 1, 0);
    checks++;
    if (y !== 128'h0 || valid !== 4'b0) begin
      errors++;
      $display("FAIL rst_shadow y=%h v=%b want 0", y, valid);
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    logic [127:0] exp;
    cycle(1, 4'b0, '0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 39) == 0,
            4'($urandom),
            d,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0);
      exp = {md[3], md[2], md[1], md[0]};
      checks++;
      if (y !== exp || valid !== mv || snap_valid !== msv) begin
        errors++;
        $display("FAIL rand%0d y=%h v=%b sv=%b want %h %b %b",
                 i, y, valid, snap_valid, exp, mv, msv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_snap_write();
    test_flush_write();
    test_dropped_restore();
    test_swap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
